// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// result sign correction. Purely combinational.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + 1'b1) : x_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned MULT and DIV on one shift/add-subtract datapath.
// Optional MULDIV_EARLY_DONE_EN: multiply leaves RUN once the multiplier is exhausted.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  state_e               state_q;
  logic                 is_div_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplr_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;

  logic                 a_sgn, b_sgn;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_acc_d;
  logic [WIDTH-1:0]     mplr_d;
  logic                 run_last;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH-1:0]     hi_d, lo_d;

  assign a_sgn = ~op[0] & a[WIDTH-1];
  assign b_sgn = ~op[0] & b[WIDTH-1];

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.x_i(a), .neg_i(a_sgn), .y_o(a_mag));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.x_i(b), .neg_i(b_sgn), .y_o(b_mag));

  // Multiply: accumulate a left-shifting multiplicand while the multiplier shifts right.
  assign mul_acc_d = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplr_d    = mplr_q >> 1;

  // Divide: acc holds {remainder, dividend/quotient}; restoring step per edge.
  assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff      = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
  assign div_acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_DONE_EN
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1)) || (!is_div_q && (mplr_d == '0));
`else
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.x_i(acc_q), .neg_i(neg_lo_q), .y_o(prod_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_fix_quo (.x_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .y_o(quo_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (.x_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_hi_q), .y_o(rem_fix));

  assign hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op[1] && (b == '0)) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              is_div_q <= op[1];
              cnt_q    <= '0;
              acc_q    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
              mcand_q  <= {{WIDTH{1'b0}}, (op[1] ? b_mag : a_mag)};
              mplr_q   <= b_mag;
              neg_lo_q <= a_sgn ^ b_sgn;
              neg_hi_q <= op[1] ? a_sgn : (a_sgn ^ b_sgn);
              busy     <= 1'b1;
              state_q  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            acc_q <= div_acc_d;
          end else begin
            acc_q   <= mul_acc_d;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_d;
          end
          if (run_last) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi      <= hi_d;
          lo      <= lo_d;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
